// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: snapshots spikes/weights on start, integrates
// one synapse per cycle with saturation, then thresholds and enters refractory.
module lif_neuron #(
   parameter int unsigned NUM_SYNAPSES   = 100,
   parameter int unsigned WIDTH_P        = 8,
   parameter int unsigned POT_W          = 16,
   parameter int unsigned THRESHOLD      = 1000,
   parameter int unsigned LEAK_SHIFT     = 3,
   parameter int unsigned REFRACT_CYCLES = 4
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            start_i,
   input  logic [NUM_SYNAPSES-1:0]         spikes_i,
   input  logic [NUM_SYNAPSES*WIDTH_P-1:0] weights_i,
   output logic                            busy_o,
   output logic                            done_o,
   output logic                            spike_o,
   output logic [POT_W-1:0]                potential_o
);

   localparam int unsigned IDX_W = (NUM_SYNAPSES > 1) ? $clog2(NUM_SYNAPSES) : 1;
   localparam int unsigned CNT_W = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYNAPSES - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRACT_CYCLES - 1);
   localparam logic [POT_W-1:0] THRESH   = POT_W'(THRESHOLD);

   typedef enum logic [1:0] {IDLE, ACCUM, EVAL, REFRACT} state_t;

   state_t               state, state_next;
   logic [IDX_W-1:0]     index;
   logic [CNT_W-1:0]     refract_cnt;
   logic [NUM_SYNAPSES-1:0] spike_snap;
   logic [WIDTH_P-1:0]   weight_snap [NUM_SYNAPSES];
   logic [POT_W:0]       sum;
   logic [POT_W-1:0]     leaked;
   logic [POT_W-1:0]     accum_val;
   logic                 fire;

   // One extra carry bit detects overflow so the potential clamps instead of wrapping.
   always_comb begin
      leaked    = potential_o - (potential_o >> LEAK_SHIFT);
      sum       = {1'b0, potential_o} + {{(POT_W + 1 - WIDTH_P){1'b0}}, weight_snap[index]};
      accum_val = sum[POT_W] ? '1 : sum[POT_W-1:0];
      fire      = (potential_o >= THRESH);
   end

   always_comb begin
      state_next = state;
      busy_o     = (state != IDLE);
      done_o     = 1'b0;
      spike_o    = 1'b0;
      case (state)
         IDLE:    if (start_i) state_next = ACCUM;
         ACCUM:   if (index == LAST_IDX) state_next = EVAL;
         EVAL: begin
            done_o     = 1'b1;
            spike_o    = fire;
            state_next = fire ? REFRACT : IDLE;
         end
         REFRACT: if (refract_cnt == LAST_CNT) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         potential_o <= '0;
         index       <= '0;
         refract_cnt <= '0;
         spike_snap  <= '0;
         for (int unsigned k = 0; k < NUM_SYNAPSES; k++) weight_snap[k] <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (start_i) begin
                  spike_snap  <= spikes_i;
                  for (int unsigned k = 0; k < NUM_SYNAPSES; k++)
                     weight_snap[k] <= weights_i[k*WIDTH_P +: WIDTH_P];
                  potential_o <= leaked;
                  index       <= '0;
               end
            end
            ACCUM: begin
               if (spike_snap[index]) potential_o <= accum_val;
               // Wrap back to 0 so the index never addresses past the last synapse.
               index <= (index == LAST_IDX) ? '0 : index + 1'b1;
            end
            EVAL: begin
               if (fire) potential_o <= '0;
               refract_cnt <= '0;
            end
            REFRACT: refract_cnt <= refract_cnt + 1'b1;
            default: ;
         endcase
      end
   end

endmodule
